// File: rtl/tenthirty_pkg.sv
`default_nettype none
// ============================================================================
// Package   : tenthirty_pkg
// Purpose   : Shared debounce state encoding and default timing constants for
//             the push-button conditioning path.
// Revision  : 1.0 - initial release
// ============================================================================
package tenthirty_pkg;

  // Debounce FSM encoding; btn_level is 1 in HELD and RELEASE_WAIT.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int unsigned C_DB_CYCLES     = 1_000_000;
  localparam int unsigned C_REPEAT_DELAY  = 25_000_000;
  localparam int unsigned C_REPEAT_PERIOD = 5_000_000;

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module    : btn_channel
// Purpose   : One button: 2-flop synchroniser, debounce FSM with stability
//             counter, registered level / press pulse / release pulse.
//             Optional auto-repeat while held, enabled by BTN_AUTOREPEAT_EN.
// Revision  : 1.0 - initial release
// ============================================================================
module btn_channel
  import tenthirty_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = C_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = C_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = C_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_rel
);

  localparam int unsigned CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  // Counter value at which the current edge completes the stable window.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             rel_q, rel_d;
  logic             db_done;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  logic             rpt_first_q, rpt_first_d;

  // Auto-repeat timer registers, only meaningful while HELD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  // Repeat timing is irrelevant without auto-repeat; referenced only so the
  // parameters stay part of the interface.
  if (REPEAT_DELAY == 0 && REPEAT_PERIOD == 0) begin : g_rpt_unused
  end
`endif

  // The stable window completes on this edge when the counter is at its last value.
  assign db_done = (cnt_q == DB_LAST);

  // Synchroniser, FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
    end
  end

  // Next-state / output decode; counting starts on the first edge a mismatch is seen.
  always_comb begin
    s1_d    = btn_raw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
`endif
    case (state_q)
      ST_IDLE, ST_PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
        end else if (db_done) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD, ST_RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = ST_HELD;
`ifdef BTN_AUTOREPEAT_EN
          // Only a full HELD cycle advances the repeat timer.
          if (state_q == ST_HELD) begin
            rpt_first_d = rpt_first_q;
            rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
            if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
              pulse_d     = 1'b1;
              rpt_cnt_d   = '0;
              rpt_first_d = 1'b0;
            end
          end
`endif
        end else if (db_done) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign btn_rel   = rel_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module    : btn_conditioner
// Purpose   : Generate wrapper: one independent btn_channel per button pin.
//             Auto-repeat is compiled in when BTN_AUTOREPEAT_EN is defined.
// Revision  : 1.0 - initial release
// ============================================================================
module btn_conditioner
  import tenthirty_pkg::*;
#(
  parameter int unsigned NUM_BTN       = 2,
  parameter int unsigned DB_CYCLES     = C_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = C_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = C_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_rel
);

  // One conditioning channel per button; channels share nothing but clock and reset.
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw[gi]),
      .btn_level (btn_level[gi]),
      .btn_pulse (btn_pulse[gi]),
      .btn_rel   (btn_rel[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module    : tb_btn_conditioner
// Purpose   : Directed self-checking bench for btn_conditioner
//             (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Revision  : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = DB + 2;  // ticks from raw change to output strobe

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, btn_pulse, btn_rel;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Statistics gathered by run(): tick index t counts from the last clear.
  int t;
  int pcnt [2];
  int rcnt [2];
  int pfirst [2];
  int rfirst [2];
  int both_cnt;
  int overlap_cnt = 0;

  btn_conditioner #(
    .NUM_BTN       (2),
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .btn_rel   (btn_rel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    t        = 0;
    both_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      pcnt[c]   = 0;
      rcnt[c]   = 0;
      pfirst[c] = -1;
      rfirst[c] = -1;
    end
  endtask

  // Advance n clock edges, sampling 1 ns after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
      for (int c = 0; c < 2; c++) begin
        if (btn_pulse[c]) begin
          pcnt[c]++;
          if (pfirst[c] < 0) pfirst[c] = t;
        end
        if (btn_rel[c]) begin
          rcnt[c]++;
          if (rfirst[c] < 0) rfirst[c] = t;
        end
      end
      if ((btn_pulse & btn_rel) != 2'b00) overlap_cnt++;
      if (btn_pulse == 2'b11) both_cnt++;
    end
  endtask

  int exp_hold;

  initial begin
    // Reset with both buttons pressed: outputs stay low throughout.
    rst_n   = 1'b0;
    btn_raw = 2'b11;
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      run(1);
      check_eq("reset_outputs", int'({btn_level, btn_pulse, btn_rel}), 0);
    end
    btn_raw = 2'b00;
    run(2);
    rst_n = 1'b1;
    run(8);
    check_eq("idle_level", int'(btn_level), 0);

    // Clean press on channel 0.
    clear_stats();
    btn_raw = 2'b01;
    run(LAT + 2);
    check_eq("press_first_tick", pfirst[0], LAT);
    check_eq("press_pulse_count", pcnt[0], 1);
    check_eq("press_level", int'(btn_level), 1);
    check_eq("press_ch1_quiet", pcnt[1] + rcnt[1], 0);

    // Release of channel 0.
    clear_stats();
    btn_raw = 2'b00;
    run(LAT + 2);
    check_eq("release_first_tick", rfirst[0], LAT);
    check_eq("release_count", rcnt[0], 1);
    check_eq("release_no_pulse", pcnt[0], 0);
    check_eq("release_level", int'(btn_level), 0);

    // Bounce: 3 high, 1 low, 3 high, then low - too short to be accepted.
    clear_stats();
    btn_raw = 2'b01; run(3);
    btn_raw = 2'b00; run(1);
    btn_raw = 2'b01; run(3);
    btn_raw = 2'b00; run(10);
    check_eq("bounce_no_pulse", pcnt[0], 0);
    check_eq("bounce_no_rel", rcnt[0], 0);
    check_eq("bounce_level", int'(btn_level), 0);

    // Minimum accepted excursion: exactly DB cycles high.
    clear_stats();
    btn_raw = 2'b01; run(DB);
    btn_raw = 2'b00; run(12);
    check_eq("min_press_pulse", pfirst[0], LAT);
    check_eq("min_press_rel", rfirst[0], DB + LAT);
    check_eq("min_press_counts", pcnt[0] + rcnt[0], 2);

    // Simultaneous press on both channels.
    clear_stats();
    btn_raw = 2'b11;
    run(LAT + 2);
    check_eq("simul_both_cycle", both_cnt, 1);
    check_eq("simul_ch1_tick", pfirst[1], LAT);
    check_eq("simul_level", int'(btn_level), 3);
    btn_raw = 2'b00;
    clear_stats();
    run(LAT + 2);
    check_eq("simul_rel_both", rcnt[0] + rcnt[1], 2);

    // Long hold on channel 0: one pulse, or repeats at +RD then every RP.
    clear_stats();
    btn_raw = 2'b01;
    run(36);
`ifdef BTN_AUTOREPEAT_EN
    exp_hold = 1 + 1 + (36 - (LAT + RD)) / RP;
`else
    exp_hold = 1;
`endif
    check_eq("hold_pulse_count", pcnt[0], exp_hold);
    check_eq("hold_level", int'(btn_level), 1);

    // Reset mid-hold: outputs clear, then a fresh press is detected.
    rst_n = 1'b0;
    run(2);
    check_eq("midhold_reset_outputs", int'({btn_level, btn_pulse, btn_rel}), 0);
    clear_stats();
    rst_n = 1'b1;
    run(LAT + 2);
    check_eq("midhold_new_pulse", pfirst[0], LAT);
    check_eq("midhold_pulse_count", pcnt[0], 1);

    check_eq("pulse_rel_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
